// File: rtl/count_refresh_ctrl_pkg.sv
// Shared definitions for the frequency-meter controller and its display
// refresh scheduler: state encodings and default sizing.
package count_refresh_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    GATE  = ST_GATE,
    LATCH = ST_LATCH
  } state_t;

  localparam int DEF_WIDTH          = 7;
  localparam int DEF_GATE_CYCLES    = 1000;
  localparam int DEF_REFRESH_CYCLES = 2500;
  localparam int DEF_BLANK_CYCLES   = 30;

endpackage

// File: rtl/refresh_divider.sv
// Free-running refresh divider: raises refresh_window for the last
// BLANK_CYCLES of each period and display_load on the final cycle.
module refresh_divider
  import count_refresh_ctrl_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  output logic refresh_window,
  output logic display_load
);

  localparam int DW = $clog2(REFRESH_CYCLES);
  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_CYCLES - 1);
  localparam logic [DW-1:0] WIN_START = DW'(REFRESH_CYCLES - BLANK_CYCLES);

  logic [DW-1:0] div;
  logic [DW-1:0] div_next;

  assign div_next = (div == DIV_LAST) ? '0 : div + DW'(1);

  // Flags are decoded from the next divider value so they line up with div
  // itself while still coming straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div            <= '0;
      refresh_window <= 1'b0;
      display_load   <= 1'b0;
    end else begin
      div            <= div_next;
      refresh_window <= (div_next >= WIN_START);
      display_load   <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/count_refresh_ctrl.sv
// Gated pulse counter with a latch that is held off while the display
// samples, so valid_count is stable across every refresh window.
module count_refresh_ctrl
  import count_refresh_ctrl_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] valid_count,
  output logic             count_valid,
  output logic             overflow,
  output logic             refresh_window,
  output logic             display_load,
  output logic             busy
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0]    GATE_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

  state_t           state;
  logic             pulse_d;
  logic             rise;
  logic [WIDTH-1:0] counter;
  logic             sat_flag;
  logic [TW-1:0]    timer;

  refresh_divider #(
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .BLANK_CYCLES  (BLANK_CYCLES)
  ) u_refresh_divider (
    .clk           (clk),
    .rst           (rst),
    .refresh_window(refresh_window),
    .display_load  (display_load)
  );

  assign rise = pulse_in & ~pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pulse_d     <= 1'b0;
      counter     <= '0;
      sat_flag    <= 1'b0;
      timer       <= '0;
      valid_count <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pulse_d     <= pulse_in;
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            counter  <= '0;
            sat_flag <= 1'b0;
            timer    <= GATE_LAST;
            state    <= GATE;
          end
        end
        GATE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // An edge that finds the counter already full marks the gate as saturated.
            if (rise) begin
              if (counter == MAX_COUNT) sat_flag <= 1'b1;
              else                      counter  <= counter + WIDTH'(1);
            end
            if (timer == '0) state <= LATCH;
            else             timer <= timer - TW'(1);
          end
        end
        LATCH: begin
          if (!refresh_window) begin
            valid_count <= counter;
            overflow    <= sat_flag;
            count_valid <= 1'b1;
            if (enable) begin
              state <= CLEAR;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/count_refresh_ctrl.md
# count_refresh_ctrl

Controller that sequences the frequency-meter datapath feeding the seven-segment display. It owns the gated pulse counter, the gate timer and the latch of the valid count. It also generates the display refresh window and strobe. The count register is never updated while the display is sampling, so `valid_count` is always stable during a refresh.

## Interface

Parameters:
- `WIDTH`, 7: width of the pulse counter and `valid_count`.
- `GATE_CYCLES`, 1000: gate length in `clk` cycles (≥ 1).
- `REFRESH_CYCLES`, 2500: display refresh period in `clk` cycles.
- `BLANK_CYCLES`, 30: length of the refresh window (1 ≤ BLANK_CYCLES < REFRESH_CYCLES).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run continuous measurements while high.
- `pulse_in`  in  1  measured signal, already synchronous to `clk`.
- `valid_count`  out  WIDTH  last latched gate count.
- `count_valid`  out  1  one-cycle strobe when `valid_count` updates.
- `overflow`  out  1  latched with `valid_count`: the gate saturated.
- `refresh_window`  out  1  high while the display samples; `valid_count` is frozen.
- `display_load`  out  1  one-cycle strobe on the last cycle of the window.
- `busy`  out  1  high in every state except IDLE.

## Operation

Measurement FSM, states IDLE, CLEAR, GATE, LATCH:
- **IDLE:** if `enable`=1, go to CLEAR.
- **CLEAR (1 cycle):**
  - pulse counter ← 0, overflow flag ← 0, gate timer ← GATE_CYCLES-1.
  - Go to GATE.
- **GATE:**
  - A rising edge is `pulse_in & ~pulse_d`, where `pulse_d` is the registered `pulse_in`. Each rising edge increments the counter.
  - The counter saturates at 2^WIDTH-1. An edge arriving at saturation sets the sticky overflow flag.
  - The timer decrements each cycle. When the timer is 0, go to LATCH.
- **LATCH:**
  - If `refresh_window`=1, stay in LATCH (deferred latch).
  - Otherwise: `valid_count` ← counter, `overflow` ← flag, `count_valid` pulses.
  - Then go to CLEAR if `enable`=1, else IDLE.
- **Dead time:** edges during CLEAR and LATCH are not counted.
- **Abort:** `enable`=0 sampled in CLEAR or GATE goes to IDLE next cycle. No latch occurs, and `valid_count`/`overflow` keep their previous values.

Refresh scheduler:
- Free-running divider counting 0..REFRESH_CYCLES-1, then wrapping to 0. It runs whenever `rst`=0, independent of `enable`.
- `refresh_window` = (div ≥ REFRESH_CYCLES-BLANK_CYCLES).
- `display_load` = (div == REFRESH_CYCLES-1).

Reset:
- Outputs all 0, FSM in IDLE.
- Divider, counter, timer and `pulse_d` all 0.
- Reset mid-gate discards the measurement immediately (asynchronous).

## Timing

- `enable` sampled high in IDLE at edge n:
  - CLEAR during cycle n+1.
  - GATE during cycles n+2 .. n+1+GATE_CYCLES.
  - LATCH reached at n+2+GATE_CYCLES.
- Undeferred: `valid_count` and `count_valid` are valid the cycle after LATCH is entered.
- Deferred: the latch occurs on the first cycle with `refresh_window`=0. Maximum deferral is BLANK_CYCLES cycles.
- Continuous mode period: GATE_CYCLES + 2 cycles plus any deferral.
- All outputs are registered. `refresh_window` and `display_load` derive from the registered divider, with no combinational path from inputs.
- Invariant: `valid_count` never changes in any cycle where `refresh_window`=1.
- Edge on the last GATE cycle is counted. Edge on the CLEAR cycle is not.

## Structure

- Shared include/package holds:
  - FSM state encodings as localparams: IDLE=0, CLEAR=1, GATE=2, LATCH=3.
  - Default WIDTH / GATE_CYCLES / REFRESH_CYCLES / BLANK_CYCLES constants.
- One sub-module, `refresh_divider`:
  - Parameterised by REFRESH_CYCLES/BLANK_CYCLES.
  - Outputs `refresh_window` and `display_load`.
  - Also used by later display blocks.
- Counter width for divider and timer: $clog2 of the respective parameter.

## Test plan

Bench parameters: WIDTH=7, GATE_CYCLES=20, REFRESH_CYCLES=50, BLANK_CYCLES=5.

- **Reset:** assert `rst` mid-run → all outputs 0 the same time step. Release → first `display_load` at cycle 49, `refresh_window` high on cycles 45–49.
- **Basic count:** `enable`=1, `pulse_in` toggling every cycle (10 rising edges in the gate) → `valid_count`=10, `overflow`=0, one `count_valid` strobe.
- **Saturation:** `pulse_in` with 200 edges over a GATE_CYCLES=400 run → `valid_count`=127, `overflow`=1. Next gate with 3 edges → `valid_count`=3, `overflow`=0.
- **Deferral:** align so LATCH is reached at divider=46 → latch occurs at divider=0. `valid_count` stays constant through cycles 45–49.
- **Abort:** drop `enable` mid-GATE → FSM returns to IDLE, `busy`=0, no `count_valid`, `valid_count` retains its previous value (10).
- **Continuous:** `enable` held high, steady 5 edges/gate → `count_valid` every 22 cycles (or later if deferred), `valid_count`=5 each time.
